sysid_pr_table: RTL and testbench



---
 rtl/sysid_pr_table.sv | 163 ++++++++++++++++
 tb/tb_sysid_pr_table.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_pr_table.sv
// Double-buffered ID-word table for the system-ID block: a PR region streams a
// new table into the shadow bank, which is then swapped in atomically.
module sysid_pr_table #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 6
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ROM_WIDTH-1:0]     s_data,
  input  logic                     s_last,
  input  logic                     pr_clear,
  input  logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic [ROM_WIDTH-1:0]     pr_rom_data,
  output logic                     pr_valid,
  output logic                     pr_overflow,
  output logic [7:0]               commit_count
);

  localparam int DEPTH = 1 << ROM_ADDR_BITS;
  localparam int LW    = ROM_ADDR_BITS + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic          active_reg, active_next;
  logic [LW-1:0] len_reg [2];
  logic [LW-1:0] wptr_reg, wptr_next;
  logic [LW-1:0] pending_reg, pending_next;
  logic          valid_reg, valid_next;
  logic          ovf_reg, ovf_next;
  logic [7:0]    count_reg, count_next;
  logic          len_clear, len_commit;
  logic          wr_en;
  logic          beat;
  logic          shadow;
  logic          rd_hit;

  // Both banks live in one array; the bank select is the address MSB.
  logic [ROM_WIDTH-1:0] mem [0:2*DEPTH-1];

  assign shadow  = ~active_reg;
  assign s_ready = !up_rst && !pr_clear && (state_reg != COMMIT);
  assign beat    = s_valid && s_ready;

  always_comb begin
    state_next   = state_reg;
    active_next  = active_reg;
    wptr_next    = wptr_reg;
    pending_next = pending_reg;
    valid_next   = valid_reg;
    ovf_next     = ovf_reg;
    count_next   = count_reg;
    len_clear    = 1'b0;
    len_commit   = 1'b0;
    wr_en        = 1'b0;
    if (pr_clear) begin
      state_next = IDLE;
      wptr_next  = '0;
      valid_next = 1'b0;
      ovf_next   = 1'b0;
      len_clear  = 1'b1;
    end else begin
      case (state_reg)
        IDLE, FILL: begin
          if (beat) begin
            if (wptr_reg < DEPTH_L) begin
              wr_en     = 1'b1;
              wptr_next = wptr_reg + LW'(1);
              if (s_last) begin
                state_next   = COMMIT;
                pending_next = wptr_reg + LW'(1);
              end else begin
                state_next = FILL;
              end
            end else begin
              // Table longer than a bank: flag it and throw the rest away.
              ovf_next = 1'b1;
              if (s_last) begin
                state_next = IDLE;
                wptr_next  = '0;
              end else begin
                state_next = DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (beat && s_last) begin
            state_next = IDLE;
            wptr_next  = '0;
          end
        end
        COMMIT: begin
          len_commit  = 1'b1;
          active_next = shadow;
          valid_next  = 1'b1;
          count_next  = count_reg + 8'd1;
          wptr_next   = '0;
          state_next  = IDLE;
        end
        default: begin
          state_next = IDLE;
          wptr_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state_reg   <= IDLE;
      active_reg  <= 1'b0;
      wptr_reg    <= '0;
      pending_reg <= '0;
      valid_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      active_reg  <= active_next;
      wptr_reg    <= wptr_next;
      pending_reg <= pending_next;
      valid_reg   <= valid_next;
      ovf_reg     <= ovf_next;
      count_reg   <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_len
      always_ff @(posedge up_clk) begin
        if (up_rst) begin
          len_reg[gi] <= '0;
        end else if (len_clear && (active_reg == 1'(gi))) begin
          len_reg[gi] <= '0;
        end else if (len_commit && (shadow == 1'(gi))) begin
          len_reg[gi] <= pending_reg;
        end
      end
    end
  endgenerate

  // RAM contents are never reset; the length registers hide stale words.
  always_ff @(posedge up_clk) begin
    if (wr_en) begin
      mem[{shadow, wptr_reg[ROM_ADDR_BITS-1:0]}] <= s_data;
    end
  end

  assign rd_hit      = valid_reg && ({1'b0, rom_addr} < len_reg[active_reg]);
  assign pr_rom_data = rd_hit ? mem[{active_reg, rom_addr}] : '0;

  assign pr_valid     = valid_reg;
  assign pr_overflow  = ovf_reg;
  assign commit_count = count_reg;

endmodule

// File: tb/tb_sysid_pr_table.sv
// Directed bench for sysid_pr_table: reset, commit, atomic swap, overflow,
// clear and reset-during-fill, with hand-computed expected values.
module tb_sysid_pr_table;

  logic        up_clk;
  logic        up_rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        pr_clear;
  logic [5:0]  rom_addr;
  logic [31:0] pr_rom_data;
  logic        pr_valid;
  logic        pr_overflow;
  logic [7:0]  commit_count;

  int total = 0;
  int bad   = 0;

  sysid_pr_table #(.ROM_WIDTH(32), .ROM_ADDR_BITS(6)) dut (
    .up_clk      (up_clk),
    .up_rst      (up_rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .pr_clear    (pr_clear),
    .rom_addr    (rom_addr),
    .pr_rom_data (pr_rom_data),
    .pr_valid    (pr_valid),
    .pr_overflow (pr_overflow),
    .commit_count(commit_count)
  );

  initial begin
    up_clk = 1'b0;
    forever #5 up_clk = ~up_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    rom_addr = a;
    #1;
    chk(tag, pr_rom_data, exp);
  endtask

  // One beat: drive on the falling edge, confirm acceptance, transfer on the rising edge.
  task automatic send(input logic [31:0] d, input logic last);
    @(negedge up_clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #1;
    chk("beat_s_ready", {31'b0, s_ready}, 32'd1);
    @(posedge up_clk);
  endtask

  // Cycle after the last beat is COMMIT; then one more falling edge lands in IDLE.
  task automatic through_commit();
    @(negedge up_clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("commit_s_ready", {31'b0, s_ready}, 32'd0);
    @(negedge up_clk);
    #1;
  endtask

  initial begin
    up_rst   = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    pr_clear = 1'b0;
    rom_addr = '0;

    // Reset
    repeat (3) @(posedge up_clk);
    @(negedge up_clk);
    #1;
    chk("rst_s_ready_held", {31'b0, s_ready}, 32'd0);
    up_rst = 1'b0;
    #1;
    chk("rst_s_ready_release", {31'b0, s_ready}, 32'd1);
    chk("rst_pr_valid", {31'b0, pr_valid}, 32'd0);
    chk("rst_overflow", {31'b0, pr_overflow}, 32'd0);
    chk("rst_count", {24'b0, commit_count}, 32'd0);
    for (int a = 0; a < 64; a++) rd("rst_data", 6'(a), 32'd0);

    // Basic commit
    send(32'hA0, 1'b0);
    send(32'hA1, 1'b0);
    send(32'hA2, 1'b0);
    send(32'hA3, 1'b1);
    @(negedge up_clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("basic_commit_s_ready", {31'b0, s_ready}, 32'd0);
    chk("basic_commit_valid_pre", {31'b0, pr_valid}, 32'd0);
    @(negedge up_clk);
    #1;
    chk("basic_s_ready_after", {31'b0, s_ready}, 32'd1);
    chk("basic_pr_valid", {31'b0, pr_valid}, 32'd1);
    chk("basic_count", {24'b0, commit_count}, 32'd1);
    rd("basic_addr0", 6'd0, 32'hA0);
    rd("basic_addr2", 6'd2, 32'hA2);
    rd("basic_addr3", 6'd3, 32'hA3);
    rd("basic_addr4", 6'd4, 32'h0);

    // Atomic swap while holding rom_addr=2
    rom_addr = 6'd2;
    send(32'hB0, 1'b0);
    #1;
    chk("swap_during_b0", pr_rom_data, 32'hA2);
    send(32'hB1, 1'b1);
    #1;
    chk("swap_during_b1", pr_rom_data, 32'hA2);
    @(negedge up_clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("swap_commit_cycle_data", pr_rom_data, 32'hA2);
    chk("swap_commit_s_ready", {31'b0, s_ready}, 32'd0);
    @(negedge up_clk);
    #1;
    chk("swap_after_addr2", pr_rom_data, 32'h0);
    rd("swap_addr1", 6'd1, 32'hB1);
    rd("swap_addr0", 6'd0, 32'hB0);
    chk("swap_count", {24'b0, commit_count}, 32'd2);

    // Overflow: 65 beats, last on the 65th
    for (int i = 0; i < 65; i++) send(32'(i), (i == 64));
    @(negedge up_clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("ovf_s_ready_idle", {31'b0, s_ready}, 32'd1);
    chk("ovf_flag", {31'b0, pr_overflow}, 32'd1);
    chk("ovf_count", {24'b0, commit_count}, 32'd2);
    chk("ovf_pr_valid", {31'b0, pr_valid}, 32'd1);
    rd("ovf_prior_addr0", 6'd0, 32'hB0);
    rd("ovf_prior_addr1", 6'd1, 32'hB1);
    rd("ovf_prior_addr2", 6'd2, 32'h0);

    // Full 64-word table serves every address
    for (int i = 0; i < 64; i++) send(32'(i) + 32'h100, (i == 63));
    through_commit();
    chk("full_count", {24'b0, commit_count}, 32'd3);
    chk("full_ovf_sticky", {31'b0, pr_overflow}, 32'd1);
    rd("full_addr0", 6'd0, 32'h100);
    rd("full_addr63", 6'd63, 32'h13F);
    rd("full_addr31", 6'd31, 32'h11F);

    // Clear on the 3rd beat of a fill
    send(32'hD0, 1'b0);
    send(32'hD1, 1'b0);
    @(negedge up_clk);
    s_valid  = 1'b1;
    s_data   = 32'hD2;
    s_last   = 1'b0;
    pr_clear = 1'b1;
    #1;
    chk("clr_s_ready", {31'b0, s_ready}, 32'd0);
    @(negedge up_clk);
    pr_clear = 1'b0;
    s_valid  = 1'b0;
    #1;
    chk("clr_pr_valid", {31'b0, pr_valid}, 32'd0);
    chk("clr_overflow", {31'b0, pr_overflow}, 32'd0);
    chk("clr_count", {24'b0, commit_count}, 32'd3);
    rd("clr_addr0", 6'd0, 32'h0);
    rd("clr_addr63", 6'd63, 32'h0);
    send(32'hE0, 1'b0);
    send(32'hE1, 1'b1);
    through_commit();
    chk("clr_recommit_valid", {31'b0, pr_valid}, 32'd1);
    chk("clr_recommit_count", {24'b0, commit_count}, 32'd4);
    rd("clr_recommit_addr0", 6'd0, 32'hE0);
    rd("clr_recommit_addr1", 6'd1, 32'hE1);
    rd("clr_recommit_addr2", 6'd2, 32'h0);

    // Reset after 10 beats of a fill
    for (int i = 0; i < 10; i++) send(32'hF0 + 32'(i), 1'b0);
    @(negedge up_clk);
    s_valid = 1'b0;
    up_rst  = 1'b1;
    @(negedge up_clk);
    #1;
    chk("mid_rst_s_ready", {31'b0, s_ready}, 32'd0);
    up_rst = 1'b0;
    #1;
    chk("mid_rst_pr_valid", {31'b0, pr_valid}, 32'd0);
    chk("mid_rst_overflow", {31'b0, pr_overflow}, 32'd0);
    chk("mid_rst_count", {24'b0, commit_count}, 32'd0);
    chk("mid_rst_s_ready_release", {31'b0, s_ready}, 32'd1);
    rd("mid_rst_addr0", 6'd0, 32'h0);
    send(32'hC0, 1'b1);
    through_commit();
    rd("single_addr0", 6'd0, 32'hC0);
    rd("single_addr1", 6'd1, 32'h0);
    chk("single_count", {24'b0, commit_count}, 32'd1);
    chk("single_pr_valid", {31'b0, pr_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
